// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit: state codes, PC-source
// selects and the instruction-class conflict helper.
package rv_ctrl_pkg;
    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5,
        ST_TRAP   = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JUMP   = 2'd2
    } pc_sel_t;

    // True when more than one instruction-class flag is set.
    function automatic logic multi_class(input logic [4:0] cls);
        return (cls & (cls - 5'd1)) != 5'd0;
    endfunction
endpackage

// File: rtl/rv_control_fsm_if.sv
// Memory handshakes, decoder class flags and datapath strobes around the
// control unit; master is the control unit, slave is the datapath/memories.
interface rv_control_fsm_if;
    logic       imem_req;
    logic       imem_ready;
    logic       ir_we;
    logic       dmem_req;
    logic       dmem_ready;
    logic       dmem_we;
    logic       dec_is_load;
    logic       dec_is_store;
    logic       dec_is_branch;
    logic       dec_is_jump;
    logic       dec_is_ecall;
    logic       dec_illegal;
    logic       branch_taken;
    logic       rf_we;
    logic       pc_we;
    logic [1:0] pc_sel;

    modport master (
        output imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pc_sel,
        input  imem_ready, dmem_ready, dec_is_load, dec_is_store, dec_is_branch,
               dec_is_jump, dec_is_ecall, dec_illegal, branch_taken
    );

    modport slave (
        input  imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pc_sel,
        output imem_ready, dmem_ready, dec_is_load, dec_is_store, dec_is_branch,
               dec_is_jump, dec_is_ecall, dec_illegal, branch_taken
    );
endinterface

// File: rtl/rv_wait_timer.sv
// Memory wait counter: expired is high on the TIMEOUT-th enabled cycle since
// the last clear, so ready on that same cycle can still be accepted.
module rv_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                   cnt <= '0;
        else if (clear)              cnt <= '0;
        else if (enable && !expired) cnt <= cnt + CW'(1);
    end

    assign expired = (cnt == CW'(TIMEOUT - 1));
endmodule

// File: rtl/rv_control_fsm.sv
// Multi-cycle control unit: fetch, decode, execute, optional memory access
// and writeback, stopping in HALT on ecall or TRAP on illegal/timeout.
module rv_control_fsm
    import rv_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               reset,
    rv_control_fsm_if.master   bus,
    output logic               halted,
    output logic               trap,
    output logic [STATE_W-1:0] state,
    output logic [31:0]        instret
);
    state_t     state_q, state_d;
    logic       expired;
    logic       mem_op;
    logic [4:0] cls;

    assign cls    = {bus.dec_is_load, bus.dec_is_store, bus.dec_is_branch,
                     bus.dec_is_jump, bus.dec_is_ecall};
    assign mem_op = bus.dec_is_load | bus.dec_is_store;
    assign state  = state_q;

    rv_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_d != state_q),
        .enable  (state_q == ST_FETCH || state_q == ST_MEM),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_FETCH;
        else       state_q <= state_d;
    end

    // Ready is tested before expiry so a late-but-in-budget response wins.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH:  if (bus.imem_ready) state_d = ST_DECODE;
                       else if (expired)   state_d = ST_TRAP;
            ST_DECODE: if (bus.dec_illegal || multi_class(cls)) state_d = ST_TRAP;
                       else if (bus.dec_is_ecall)              state_d = ST_HALT;
                       else                                    state_d = ST_EXEC;
            ST_EXEC:   if (mem_op)                 state_d = ST_MEM;
                       else if (bus.dec_is_branch) state_d = ST_FETCH;
                       else                        state_d = ST_WB;
            ST_MEM:    if (bus.dmem_ready) state_d = bus.dec_is_store ? ST_FETCH : ST_WB;
                       else if (expired)   state_d = ST_TRAP;
            ST_WB:     state_d = ST_FETCH;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_TRAP;
        endcase
    end

    // Gated by reset so requests and strobes drop as soon as reset rises.
    always_comb begin
        bus.imem_req = 1'b0;
        bus.ir_we    = 1'b0;
        bus.dmem_req = 1'b0;
        bus.dmem_we  = 1'b0;
        bus.rf_we    = 1'b0;
        bus.pc_we    = 1'b0;
        bus.pc_sel   = PC_PLUS4;
        halted       = 1'b0;
        trap         = 1'b0;
        if (!reset) begin
            case (state_q)
                ST_FETCH: begin
                    bus.imem_req = 1'b1;
                    bus.ir_we    = bus.imem_ready;
                end
                ST_DECODE: ;
                ST_EXEC: if (!mem_op && bus.dec_is_branch) begin
                    bus.pc_we  = 1'b1;
                    bus.pc_sel = bus.branch_taken ? PC_BRANCH : PC_PLUS4;
                end
                ST_MEM: begin
                    bus.dmem_req = 1'b1;
                    bus.dmem_we  = bus.dec_is_store;
                    bus.pc_we    = bus.dmem_ready && bus.dec_is_store;
                end
                ST_WB: begin
                    bus.rf_we  = 1'b1;
                    bus.pc_we  = 1'b1;
                    bus.pc_sel = bus.dec_is_jump ? PC_JUMP : PC_PLUS4;
                end
                ST_HALT: halted = 1'b1;
                default: trap   = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)          instret <= '0;
        else if (bus.pc_we) instret <= instret + 32'd1;
    end
endmodule
